// File: rtl/motion_vector_encode_if.sv
// Request/response bundle for motion_vector_encode: request handshake with the
// vector and predictor, the putbits word stream, and the updated PMV pair.
interface motion_vector_encode_if #(
    parameter int unsigned PW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [PW-1:0] in_pred_h;
    logic signed [PW-1:0] in_pred_v;
    logic signed [PW-1:0] in_mv_h;
    logic signed [PW-1:0] in_mv_v;
    logic                 in_mvfs_en;
    logic                 in_mvfs;
    logic                 mvscale;
    logic [31:0]          out_word;
    logic [4:0]           out_len;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [PW-1:0] out_pmv_h;
    logic signed [PW-1:0] out_pmv_v;
    logic                 done;

    // Requester / packer side
    modport master (
        output in_valid, in_pred_h, in_pred_v, in_mv_h, in_mv_v,
        output in_mvfs_en, in_mvfs, mvscale, out_ready,
        input  in_ready, out_word, out_len, out_valid, out_pmv_h, out_pmv_v, done
    );

    // Encoder side
    modport slave (
        input  in_valid, in_pred_h, in_pred_v, in_mv_h, in_mv_v,
        input  in_mvfs_en, in_mvfs, mvscale, out_ready,
        output in_ready, out_word, out_len, out_valid, out_pmv_h, out_pmv_v, done
    );
endinterface

// File: rtl/motion_vector_encode.sv
// MPEG-2 motion vector encoder: codes one vector against its predictor as an
// optional field-select bit, then horizontal and vertical motion_code VLC +
// sign + residual words, one right-justified word per handshake.
// PW must match the PW of the connected interface.
module motion_vector_encode #(
    parameter int unsigned H_R_SIZE = 1,
    parameter int unsigned V_R_SIZE = 1,
    parameter int unsigned PW       = 16
) (
    input logic                   clk,
    input logic                   rst,
    motion_vector_encode_if.slave bus
);
    localparam int unsigned DW = PW + 2;

    typedef logic signed [DW-1:0] dval_t;

    typedef struct packed {
        logic [31:0] word;
        logic [4:0]  len;
    } field_t;

    typedef enum logic [2:0] {
        StIdle, StFs, StCalcH, StEmitH, StCalcV, StEmitV, StDone
    } state_t;

    state_t               state_q, state_d;
    logic signed [PW-1:0] pred_h_q, pred_v_q, mv_h_q, mv_v_q;
    logic                 mvscale_q;
    logic [31:0]          word_q, word_d;
    logic [4:0]           len_q, len_d;
    logic signed [PW-1:0] pmv_h_q, pmv_h_d, pmv_v_q, pmv_v_d;
    logic signed [PW-1:0] pred_v_eff;
    logic                 in_ready, accept, xfer;
    field_t               field_h, field_v;

    // motion_code VLC, codes 0..16 (16 falls to default)
    function automatic field_t vlc_lookup(input logic [4:0] code);
        field_t v;
        case (code)
            5'd0:    v = '{word: 32'h001, len: 5'd1};
            5'd1:    v = '{word: 32'h001, len: 5'd2};
            5'd2:    v = '{word: 32'h001, len: 5'd3};
            5'd3:    v = '{word: 32'h001, len: 5'd4};
            5'd4:    v = '{word: 32'h003, len: 5'd6};
            5'd5:    v = '{word: 32'h005, len: 5'd7};
            5'd6:    v = '{word: 32'h004, len: 5'd7};
            5'd7:    v = '{word: 32'h003, len: 5'd7};
            5'd8:    v = '{word: 32'h00B, len: 5'd9};
            5'd9:    v = '{word: 32'h00A, len: 5'd9};
            5'd10:   v = '{word: 32'h009, len: 5'd9};
            5'd11:   v = '{word: 32'h011, len: 5'd10};
            5'd12:   v = '{word: 32'h010, len: 5'd10};
            5'd13:   v = '{word: 32'h00F, len: 5'd10};
            5'd14:   v = '{word: 32'h00E, len: 5'd10};
            5'd15:   v = '{word: 32'h00D, len: 5'd10};
            default: v = '{word: 32'h00C, len: 5'd10};
        endcase
        return v;
    endfunction

    // Wrap the difference into [-16f, 16f-1], split into code/residual, pack the word
    function automatic field_t encode(input logic signed [PW-1:0] mv,
                                      input logic signed [PW-1:0] pred,
                                      input int unsigned          r);
        dval_t       f, delta, mag;
        logic [DW-1:0] t, res;
        logic [4:0]  code;
        field_t      fld;
        f     = dval_t'(1) << r;
        delta = dval_t'(mv) - dval_t'(pred);
        if (delta > (f <<< 4) - dval_t'(1)) begin
            delta = delta - (f <<< 5);
        end else if (delta < -(f <<< 4)) begin
            delta = delta + (f <<< 5);
        end
        mag  = delta[DW-1] ? -delta : delta;
        t    = mag + f - dval_t'(1);
        code = 5'(t >> r);
        res  = t & (f - dval_t'(1));
        fld  = vlc_lookup(code);
        if (code != 5'd0) begin
            fld.word = {fld.word[30:0], delta[DW-1]};
            fld.len  = fld.len + 5'd1;
            if (r != 0) begin
                fld.word = (fld.word << r) | 32'(res);
                fld.len  = fld.len + 5'(r);
            end
        end
        return fld;
    endfunction

    assign in_ready = (state_q == StIdle);
    assign accept   = bus.in_valid & in_ready;
    assign xfer     = bus.out_valid & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StFs) || (state_q == StEmitH) || (state_q == StEmitV);
    assign bus.done      = (state_q == StDone);
    assign bus.out_word  = word_q;
    assign bus.out_len   = len_q;
    assign bus.out_pmv_h = pmv_h_q;
    assign bus.out_pmv_v = pmv_v_q;

    // Field words from the captured request
    always_comb begin
        pred_v_eff = mvscale_q ? (pred_v_q >>> 1) : pred_v_q;
        field_h    = encode(mv_h_q, pred_h_q, H_R_SIZE);
        field_v    = encode(mv_v_q, pred_v_eff, V_R_SIZE);
    end

    // Next state, output word and PMV update
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        pmv_h_d = pmv_h_q;
        pmv_v_d = pmv_v_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.in_mvfs_en) begin
                        state_d = StFs;
                        word_d  = {31'b0, bus.in_mvfs};
                        len_d   = 5'd1;
                    end else begin
                        state_d = StCalcH;
                    end
                end
            end
            StFs: if (xfer) state_d = StCalcH;
            StCalcH: begin
                word_d  = field_h.word;
                len_d   = field_h.len;
                state_d = StEmitH;
            end
            StEmitH: if (xfer) state_d = StCalcV;
            StCalcV: begin
                word_d  = field_v.word;
                len_d   = field_v.len;
                state_d = StEmitV;
            end
            StEmitV: begin
                // PMV loads on entry to StDone so it is valid while done is high
                if (xfer) begin
                    state_d = StDone;
                    pmv_h_d = mv_h_q;
                    pmv_v_d = mvscale_q ? (mv_v_q <<< 1) : mv_v_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            len_q   <= '0;
            pmv_h_q <= '0;
            pmv_v_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            pmv_h_q <= pmv_h_d;
            pmv_v_q <= pmv_v_d;
        end
    end

    // Request capture on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_h_q  <= '0;
            pred_v_q  <= '0;
            mv_h_q    <= '0;
            mv_v_q    <= '0;
            mvscale_q <= 1'b0;
        end else if (accept) begin
            pred_h_q  <= bus.in_pred_h;
            pred_v_q  <= bus.in_pred_v;
            mv_h_q    <= bus.in_mv_h;
            mv_v_q    <= bus.in_mv_v;
            mvscale_q <= bus.mvscale;
        end
    end
endmodule

// File: tb/tb_motion_vector_encode.sv
// Bench for motion_vector_encode: directed cases plus randomized requests checked
// against an arithmetic reference model of the motion-vector coding rules.
module tb_motion_vector_encode;
    localparam int unsigned PW = 16;
    localparam int          HR = 1;
    localparam int          VR = 1;

    logic clk;
    logic rst;

    motion_vector_encode_if #(.PW(PW)) bus ();

    motion_vector_encode #(
        .H_R_SIZE(HR),
        .V_R_SIZE(VR),
        .PW      (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed transaction
    logic [31:0]   got_w[$];
    logic [4:0]    got_l[$];
    logic [PW-1:0] got_pmv_h, got_pmv_v;
    bit            got_done, done_wide, busy_ready, timed_out;
    int            got_lat;

    // Expected transaction
    logic [31:0] exp_w[$];
    int          exp_l[$];
    int          exp_pmv_h, exp_pmv_v;

    int vlc_val [0:16] = '{1, 1, 1, 1, 3, 5, 4, 3, 11, 10, 9, 17, 16, 15, 14, 13, 12};
    int vlc_len [0:16] = '{1, 2, 3, 4, 6, 7, 7, 7, 9, 9, 9, 10, 10, 10, 10, 10, 10};

    // Reference: one component word from plain integer arithmetic
    function automatic void model_field(input int mv, input int pred, input int r,
                                        output logic [31:0] w, output int len);
        int f, d, t, code, res;
        f = 1 << r;
        d = mv - pred;
        if (d > 16 * f - 1) d = d - 32 * f;
        else if (d < -16 * f) d = d + 32 * f;
        t    = ((d < 0) ? -d : d) + f - 1;
        code = t / f;
        res  = t % f;
        w    = 32'(vlc_val[code]);
        len  = vlc_len[code];
        if (code != 0) begin
            w   = w * 32'd2 + ((d < 0) ? 32'd1 : 32'd0);
            w   = w * 32'(f) + 32'(res);
            len = len + 1 + r;
        end
    endfunction

    task automatic model_txn(input int ph, input int pv, input int mh, input int mv,
                             input bit fs_en, input bit fs, input bit sc);
        logic [31:0] w;
        int          l;
        exp_w.delete();
        exp_l.delete();
        if (fs_en) begin
            exp_w.push_back(32'(fs));
            exp_l.push_back(1);
        end
        model_field(mh, ph, HR, w, l);
        exp_w.push_back(w);
        exp_l.push_back(l);
        model_field(mv, sc ? (pv >>> 1) : pv, VR, w, l);
        exp_w.push_back(w);
        exp_l.push_back(l);
        exp_pmv_h = mh;
        exp_pmv_v = sc ? mv * 2 : mv;
    endtask

    function automatic int rnd_mv(input int r);
        int f;
        f = 1 << r;
        return int'($urandom_range(32 * f - 1)) - 16 * f;
    endfunction

    // Issue one request and collect every accepted word until done
    task automatic do_txn(input int ph, input int pv, input int mh, input int mv,
                          input bit fs_en, input bit fs, input bit sc,
                          input int rdy_pct, input bit busy_poke);
        int n;
        got_w.delete();
        got_l.delete();
        got_done   = 0;
        done_wide  = 0;
        busy_ready = 0;
        timed_out  = 0;
        got_lat    = -1;
        @(negedge clk);
        bus.in_pred_h  = PW'(ph);
        bus.in_pred_v  = PW'(pv);
        bus.in_mv_h    = PW'(mh);
        bus.in_mv_v    = PW'(mv);
        bus.in_mvfs_en = fs_en;
        bus.in_mvfs    = fs;
        bus.mvscale    = sc;
        bus.in_valid   = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) timed_out = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (n < 400) begin
            if (bus.done) begin
                got_done  = 1;
                got_pmv_h = bus.out_pmv_h;
                got_pmv_v = bus.out_pmv_v;
                break;
            end
            if (bus.in_ready) busy_ready = 1;
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            if (busy_poke) begin
                bus.in_valid   = 1'($urandom);
                bus.in_pred_h  = PW'($urandom);
                bus.in_mv_h    = PW'($urandom);
                bus.in_mv_v    = PW'($urandom);
                bus.in_mvfs_en = 1'($urandom);
                bus.mvscale    = 1'($urandom);
            end
            if (bus.out_valid) begin
                if (got_lat < 0) got_lat = n;
                if (bus.out_ready) begin
                    got_w.push_back(bus.out_word);
                    got_l.push_back(bus.out_len);
                end
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (!got_done) timed_out = 1;
        @(negedge clk);
        if (bus.done) done_wide = 1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid);
        end
        checks++;
        if (bus.out_word !== 32'h0 || bus.out_len !== 5'd0) begin
            errors++;
            $display("FAIL reset_word got=%0h/%0d want=0/0", bus.out_word, bus.out_len);
        end
        checks++;
        if (bus.out_pmv_h !== '0 || bus.out_pmv_v !== '0) begin
            errors++;
            $display("FAIL reset_pmv got=%0h/%0h want=0/0", bus.out_pmv_h, bus.out_pmv_v);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%0b want=0", bus.done);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%0b want=1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        do_txn(0, 0, 3, 0, 0, 0, 0, 100, 0);
        checks++;
        if (timed_out || got_w.size() != 2) begin
            errors++; $display("FAIL basic_count got=%0d want=2", got_w.size());
        end else begin
            checks++;
            if (got_w[0] !== 32'h04 || got_l[0] !== 5'd5) begin
                errors++; $display("FAIL basic_h got=%0h/%0d want=4/5", got_w[0], got_l[0]);
            end
            checks++;
            if (got_w[1] !== 32'h1 || got_l[1] !== 5'd1) begin
                errors++; $display("FAIL basic_v got=%0h/%0d want=1/1", got_w[1], got_l[1]);
            end
        end
        checks++;
        if (got_lat !== 2) begin
            errors++; $display("FAIL basic_latency got=%0d want=2", got_lat);
        end
        checks++;
        if (got_pmv_h !== PW'(3) || got_pmv_v !== PW'(0)) begin
            errors++; $display("FAIL basic_pmv got=%0h/%0h want=3/0", got_pmv_h, got_pmv_v);
        end
        checks++;
        if (done_wide || busy_ready) begin
            errors++;
            $display("FAIL basic_done_ready got=%0b/%0b want=0/0", done_wide, busy_ready);
        end
    endtask

    task automatic test_neg_and_wrap();
        do_txn(0, 0, -3, 0, 0, 0, 0, 100, 0);
        checks++;
        if (got_w.size() < 1 || got_w[0] !== 32'h06 || got_l[0] !== 5'd5) begin
            errors++; $display("FAIL neg_h got=%0h/%0d want=6/5",
                               (got_w.size() > 0) ? got_w[0] : 32'hx,
                               (got_l.size() > 0) ? got_l[0] : 5'hx);
        end
        do_txn(30, 0, -30, 0, 0, 0, 0, 100, 0);
        checks++;
        if (got_w.size() < 1 || got_w[0] !== 32'h05 || got_l[0] !== 5'd5) begin
            errors++; $display("FAIL wrap_h got=%0h/%0d want=5/5",
                               (got_w.size() > 0) ? got_w[0] : 32'hx,
                               (got_l.size() > 0) ? got_l[0] : 5'hx);
        end
    endtask

    task automatic test_max_len_fs();
        do_txn(0, 0, -32, 0, 1, 1, 0, 100, 0);
        checks++;
        if (timed_out || got_w.size() != 3) begin
            errors++; $display("FAIL maxlen_count got=%0d want=3", got_w.size());
        end else begin
            checks++;
            if (got_w[0] !== 32'h1 || got_l[0] !== 5'd1) begin
                errors++; $display("FAIL maxlen_fs got=%0h/%0d want=1/1", got_w[0], got_l[0]);
            end
            checks++;
            if (got_w[1] !== 32'h033 || got_l[1] !== 5'd12) begin
                errors++; $display("FAIL maxlen_h got=%0h/%0d want=33/12", got_w[1], got_l[1]);
            end
        end
        checks++;
        if (got_lat !== 1) begin
            errors++; $display("FAIL fs_latency got=%0d want=1", got_lat);
        end
    endtask

    task automatic test_mvscale();
        do_txn(0, 8, 0, 6, 0, 0, 1, 100, 0);
        checks++;
        if (got_w.size() != 2 || got_w[1] !== 32'h05 || got_l[1] !== 5'd4) begin
            errors++; $display("FAIL mvscale_v got=%0h/%0d want=5/4",
                               (got_w.size() > 1) ? got_w[1] : 32'hx,
                               (got_l.size() > 1) ? got_l[1] : 5'hx);
        end
        checks++;
        if (got_pmv_v !== PW'(12)) begin
            errors++; $display("FAIL mvscale_pmv got=%0d want=12", got_pmv_v);
        end
    endtask

    task automatic test_random(input int count, input int rdy_pct, input bit poke);
        int  ph, pv, mh, mv;
        bit  fs_en, fs, sc;
        for (int k = 0; k < count; k++) begin
            ph    = rnd_mv(HR);
            mh    = rnd_mv(HR);
            pv    = rnd_mv(VR);
            mv    = rnd_mv(VR);
            fs_en = 1'($urandom);
            fs    = 1'($urandom);
            sc    = 1'($urandom);
            model_txn(ph, pv, mh, mv, fs_en, fs, sc);
            do_txn(ph, pv, mh, mv, fs_en, fs, sc, rdy_pct, poke);
            checks++;
            if (timed_out || got_w.size() != exp_w.size()) begin
                errors++; $display("FAIL rand_count txn=%0d got=%0d want=%0d",
                                   k, got_w.size(), exp_w.size());
            end else begin
                for (int i = 0; i < got_w.size(); i++) begin
                    checks++;
                    if ({got_w[i], got_l[i]} !== {exp_w[i], 5'(exp_l[i])}) begin
                        errors++; $display("FAIL rand_word txn=%0d idx=%0d got=%0h/%0d want=%0h/%0d",
                                           k, i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
                    end
                end
            end
            checks++;
            if (got_pmv_h !== PW'(exp_pmv_h) || got_pmv_v !== PW'(exp_pmv_v)) begin
                errors++; $display("FAIL rand_pmv txn=%0d got=%0h/%0h want=%0h/%0h", k,
                                   got_pmv_h, got_pmv_v, PW'(exp_pmv_h), PW'(exp_pmv_v));
            end
            checks++;
            if (done_wide || busy_ready) begin
                errors++; $display("FAIL rand_done_ready txn=%0d got=%0b/%0b want=0/0",
                                   k, done_wide, busy_ready);
            end
        end
    endtask

    task automatic test_stall_reset();
        logic [31:0] w0, ew;
        logic [4:0]  l0;
        int          el, n;
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.in_pred_h  = PW'(1);
        bus.in_mv_h    = PW'(-7);
        bus.in_pred_v  = '0;
        bus.in_mv_v    = '0;
        bus.in_mvfs_en = 1'b0;
        bus.mvscale    = 1'b0;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        model_field(-7, 1, HR, ew, el);
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_word, bus.out_len} !== {ew, 5'(el)}) begin
            errors++; $display("FAIL stall_first got=%0b %0h/%0d want=1 %0h/%0d",
                               bus.out_valid, bus.out_word, bus.out_len, ew, el);
        end
        w0 = bus.out_word;
        l0 = bus.out_len;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_word !== w0 || bus.out_len !== l0) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%0b %0h/%0d want=1 %0h/%0d",
                                   i, bus.out_valid, bus.out_word, bus.out_len, w0, l0);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_word !== 32'h0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset got=%0b/%0h/%0b want=0/0/1",
                               bus.out_valid, bus.out_word, bus.in_ready);
        end
        checks++;
        if (bus.out_pmv_h !== '0 || bus.out_pmv_v !== '0) begin
            errors++; $display("FAIL midreset_pmv got=%0h/%0h want=0/0",
                               bus.out_pmv_h, bus.out_pmv_v);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        do_txn(0, 0, 3, 0, 0, 0, 0, 100, 0);
        checks++;
        if (got_w.size() != 2 || got_w[0] !== 32'h04 || got_l[0] !== 5'd5
            || got_w[1] !== 32'h1 || got_l[1] !== 5'd1 || got_pmv_h !== PW'(3)) begin
            errors++; $display("FAIL post_reset got=%0d words pmv_h=%0h want=2 words 4/5 1/1 pmv_h=3",
                               got_w.size(), got_pmv_h);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_pred_h  = '0;
        bus.in_pred_v  = '0;
        bus.in_mv_h    = '0;
        bus.in_mv_v    = '0;
        bus.in_mvfs_en = 1'b0;
        bus.in_mvfs    = 1'b0;
        bus.mvscale    = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_neg_and_wrap();
        test_max_len_fs();
        test_mvscale();
        test_random(60, 50, 1'b1);
        test_random(15, 100, 1'b0);
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
